// File: rtl/riscv_div_ctrl.sv
// Multi-cycle restoring divider controller for the RV64M divide/remainder ops.
// Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
`timescale 1ns/1ps
module riscv_div_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  input  logic            i_riscv_div_start,
  input  logic [1:0]      i_riscv_div_op,
  input  logic            i_riscv_div_word,
  input  logic [XLEN-1:0] i_riscv_div_rs1,
  input  logic [XLEN-1:0] i_riscv_div_rs2,
  input  logic            i_riscv_div_flush,
  output logic            o_riscv_div_stall,
  output logic            o_riscv_div_valid,
  output logic [XLEN-1:0] o_riscv_div_result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned WW = 32;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Magnitude of an operand at the operating width; op[0]=1 means unsigned.
  function automatic logic [XLEN-1:0] fn_mag(input logic [1:0] op, input logic word,
                                             input logic [XLEN-1:0] v);
    logic [WW-1:0]   v32;
    logic [XLEN-1:0] vx;
    v32 = v[WW-1:0];
    vx  = v;
    if (word) begin
      if (!op[0] && v32[WW-1]) v32 = -v32;
      return XLEN'(v32);
    end
    if (!op[0] && vx[XLEN-1]) vx = -vx;
    return vx;
  endfunction

  function automatic logic fn_special(input logic [1:0] op, input logic word,
                                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic dz;
    logic ovf;
    if (word) begin
      dz  = (b[WW-1:0] == '0);
      ovf = !op[0] && (a[WW-1:0] == {1'b1, {(WW-1){1'b0}}}) && (b[WW-1:0] == '1);
    end else begin
      dz  = (b == '0);
      ovf = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end
    return dz || ovf;
  endfunction

  // Apply signs and the divide-by-zero / overflow overrides to the unsigned step results.
  function automatic logic [XLEN-1:0] fn_finish(input logic [1:0] op, input logic word,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input logic [XLEN-1:0] qmag, input logic [XLEN-1:0] rmag);
    logic            neg_q;
    logic            neg_r;
    logic [WW-1:0]   a32;
    logic [WW-1:0]   b32;
    logic [WW-1:0]   q32;
    logic [WW-1:0]   r32;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    a32 = a[WW-1:0];
    b32 = b[WW-1:0];
    if (word) begin
      neg_r = !op[0] && a32[WW-1];
      neg_q = neg_r ^ (!op[0] && b32[WW-1]);
      q32 = qmag[WW-1:0];
      r32 = rmag[WW-1:0];
      if (neg_q) q32 = -q32;
      if (neg_r) r32 = -r32;
      if (b32 == '0) begin
        q32 = '1;
        r32 = a32;
      end else if (!op[0] && a32 == {1'b1, {(WW-1){1'b0}}} && b32 == '1) begin
        q32 = a32;
        r32 = '0;
      end
      return op[1] ? XLEN'($signed(r32)) : XLEN'($signed(q32));
    end
    neg_r = !op[0] && a[XLEN-1];
    neg_q = neg_r ^ (!op[0] && b[XLEN-1]);
    q = qmag;
    r = rmag;
    if (neg_q) q = -q;
    if (neg_r) r = -r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end
    return op[1] ? r : q;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [1:0]      r_op;
  logic            r_word;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic            w_special;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
  assign w_special = fn_special(i_riscv_div_op, i_riscv_div_word, i_riscv_div_rs1, i_riscv_div_rs2);

  assign o_riscv_div_stall  = !i_riscv_rst &&
                              (((r_state == S_IDLE) && i_riscv_div_start && !i_riscv_div_flush) ||
                               (r_state == S_BUSY));
  assign o_riscv_div_valid  = r_valid;
  assign o_riscv_div_result = r_result;

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_riscv_div_start && !i_riscv_div_flush) begin
            r_rs1  <= i_riscv_div_rs1;
            r_rs2  <= i_riscv_div_rs2;
            r_op   <= i_riscv_div_op;
            r_word <= i_riscv_div_word;
            r_rem  <= '0;
            // W dividends sit in the top 32 bits so only 32 steps are needed.
            r_quo  <= i_riscv_div_word ?
                      (fn_mag(i_riscv_div_op, 1'b1, i_riscv_div_rs1) << (XLEN - WW)) :
                      fn_mag(i_riscv_div_op, 1'b0, i_riscv_div_rs1);
            r_dvs  <= fn_mag(i_riscv_div_op, i_riscv_div_word, i_riscv_div_rs2);
            r_cnt  <= i_riscv_div_word ? CW'(WW) : CW'(XLEN);
`ifdef RISCV_DIV_EARLY_OUT_EN
            if (w_special) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_cnt    <= '0;
              r_result <= fn_finish(i_riscv_div_op, i_riscv_div_word, i_riscv_div_rs1,
                                    i_riscv_div_rs2, '0, '0);
            end else begin
              r_state <= S_BUSY;
            end
`else
            r_state <= w_special ? S_BUSY : S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          if (i_riscv_div_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= fn_finish(r_op, r_word, r_rs1, r_rs2, w_quo_nx, w_rem_nx);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Directed self-checking bench for riscv_div_ctrl (XLEN=64), honours RISCV_DIV_EARLY_OUT_EN.
`timescale 1ns/1ps
module tb_riscv_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int LAT64 = 65;
  localparam int LAT32 = 33;
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int LSP64 = 1;
  localparam int LSP32 = 1;
`else
  localparam int LSP64 = 65;
  localparam int LSP32 = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        flush;
  logic        stall;
  logic        valid;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  riscv_div_ctrl #(.XLEN(64)) dut (
    .i_riscv_clk        (clk),
    .i_riscv_rst        (rst),
    .i_riscv_div_start  (start),
    .i_riscv_div_op     (op),
    .i_riscv_div_word   (word),
    .i_riscv_div_rs1    (rs1),
    .i_riscv_div_rs2    (rs2),
    .i_riscv_div_flush  (flush),
    .o_riscv_div_stall  (stall),
    .o_riscv_div_valid  (valid),
    .o_riscv_div_result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start held from cycle 0 through DONE; valid expected exactly at cycle lat.
  task automatic do_op(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    start = 1'b1; op = o; word = w; rs1 = a; rs2 = b;
    for (int c = 0; c <= lat; c++) begin
      #2;
      if (c < lat) begin
        if (stall !== 1'b1 || valid !== 1'b0) begin
          chk({tag, "_stall"}, 64'(stall), 64'd1);
          chk({tag, "_early_valid"}, 64'(valid), 64'd0);
        end
      end else begin
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_done_stall"}, 64'(stall), 64'd0);
        chk({tag, "_result"}, result, exp);
      end
      next_cycle();
    end
    start = 1'b0;
    #2;
    chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
    chk({tag, "_idle_stall"}, 64'(stall), 64'd0);
    chk({tag, "_hold"}, result, exp);
    next_cycle();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; word = 1'b0; rs1 = '0; rs2 = '0;
    #2;
    start = 1'b1; op = OP_DIVU; rs1 = 64'd100; rs2 = 64'd7;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_result", result, 64'd0);
    start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    do_op("divu", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT64);
    do_op("remu", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, LAT64);
    do_op("div_neg", OP_DIV, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, LAT64);
    do_op("rem_neg", OP_REM, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, LAT64);
    do_op("div_negdvs", OP_DIV, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT64);
    do_op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, LSP32);
    do_op("remuw", OP_REMU, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'h10, 64'd0, LAT32);
    do_op("divuw_sext", OP_DIVU, 1'b1, 64'hABCD_0000_FFFF_FFFE, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFE, LAT32);
    do_op("remw_neg", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT32);
    do_op("divu_dz", OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LSP64);
    do_op("rem_dz", OP_REM, 1'b0, 64'd5, 64'd0, 64'd5, LSP64);
    do_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, LSP64);
    do_op("remw_dz", OP_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
          64'hFFFF_FFFF_8000_0001, LSP32);

    // Flush beats start in IDLE.
    start = 1'b1; flush = 1'b1; op = OP_DIVU; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7;
    #2;
    chk("idle_flush_stall", 64'(stall), 64'd0);
    next_cycle();
    start = 1'b0; flush = 1'b0;
    #2;
    chk("idle_flush_no_busy", 64'(stall), 64'd0);
    chk("idle_flush_valid", 64'(valid), 64'd0);
    next_cycle();

    // Flush mid-BUSY, then a fresh DIVU 9/3 at cycle 11.
    start = 1'b1; op = OP_DIVU; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (stall !== 1'b1) chk("flush_pre_stall", 64'(stall), 64'd1);
      next_cycle();
    end
    flush = 1'b1;
    #2;
    chk("flush_busy_stall", 64'(stall), 64'd1);
    chk("flush_busy_valid", 64'(valid), 64'd0);
    next_cycle();
    flush = 1'b0; start = 1'b0;
    #2;
    chk("flush_after_stall", 64'(stall), 64'd0);
    chk("flush_after_valid", 64'(valid), 64'd0);
    do_op("divu_after_flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, LAT64);

    // Asynchronous reset at BUSY cycle 20.
    start = 1'b1; op = OP_DIVU; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7;
    for (int c = 0; c < 20; c++) next_cycle();
    #2;
    chk("busy20_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    next_cycle();
    next_cycle();
    start = 1'b0;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 70; c++) begin
        #2;
        if (valid === 1'b1 || stall === 1'b1) seen++;
        next_cycle();
      end
      chk("postrst_quiet", 64'(seen), 64'd0);
    end
    do_op("postrst_remuw", OP_REMU, 1'b1, 64'h0000_0000_0000_0064, 64'd7, 64'd2, LAT32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_div_ctrl.md
RISCV_DIV_CTRL -- requirements
Module: riscv_div_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the operand and result width.
REQ-002 The block SHALL have port i_riscv_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_riscv_rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_riscv_div_start  input  1  the execute stage holds a valid M-extension divide/remainder op.
REQ-005 The block SHALL have port i_riscv_div_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port i_riscv_div_word  input  1  W variant (DIVW/DIVUW/REMW/REMUW).
REQ-007 The block SHALL have ports i_riscv_div_rs1 and i_riscv_div_rs2  input  XLEN each  dividend and divisor.
REQ-008 The block SHALL have port i_riscv_div_flush  input  1  kill of the instruction in execute.
REQ-009 The block SHALL have port o_riscv_div_stall  output  1  freeze of the fetch/decode/execute pipeline registers.
REQ-010 The block SHALL have port o_riscv_div_valid  output  1  one-cycle strobe: result is ready.
REQ-011 The block SHALL have port o_riscv_div_result  output  XLEN  quotient or remainder.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 IDLE with start=1 and flush=0: operands, op and word are latched, the iteration counter is loaded with XLEN (non-W) or 32 (W), and the next state is BUSY.
REQ-014 In BUSY, each cycle SHALL perform one restoring shift-subtract step and decrement the counter; when the counter reaches 1, the next state is DONE.
REQ-015 DONE SHALL last exactly one cycle with valid=1 and the result held stable, then return to IDLE; start is ignored in DONE because the same instruction is still in execute.
REQ-016 Stall SHALL be combinational: stall = (IDLE and start and not flush) or BUSY. Stall SHALL be 0 in DONE so the pipeline advances on the DONE edge.
REQ-017 Latency: with start first seen in IDLE at cycle 0, valid SHALL assert at cycle N+1 (N=64 non-W, 32 W), and stall SHALL be high for cycles 0..N.
REQ-018 Signed ops (DIV/REM) SHALL divide magnitudes. The quotient is negated when the operand signs differ, and the remainder takes the dividend's sign.
REQ-019 W ops SHALL use rs1[31:0] and rs2[31:0] only, with the signedness set by op, and SHALL sign-extend the 32-bit result to XLEN (DIVUW/REMUW included).
REQ-020 Divide by zero SHALL give quotient all-ones and remainder = dividend, at the operating width, then sign-extended for W ops.
REQ-021 Signed overflow (most-negative / -1) SHALL give quotient = dividend and remainder 0, at the operating width.
REQ-022 Flush SHALL win over start. Flush in any state SHALL send the FSM to IDLE on the next edge with no valid pulse, and stall SHALL be 0 in that flush cycle when the state is IDLE or DONE.
REQ-023 o_riscv_div_result SHALL hold its last value outside DONE; the result is only meaningful while valid=1.

Reset
REQ-024 Asserting i_riscv_rst at any time, including mid-BUSY, SHALL immediately force IDLE, counter 0, the internal remainder/quotient registers 0, o_riscv_div_result 0, and o_riscv_div_valid 0.
REQ-025 During reset, o_riscv_div_stall SHALL be 0 regardless of start. After deassertion, the first start SHALL be accepted normally.

Configuration
REQ-026 Macro RISCV_DIV_EARLY_OUT_EN, when defined: divide-by-zero and signed-overflow cases SHALL go IDLE to DONE directly, so valid appears at cycle 1 and stall is high for cycle 0 only.
REQ-027 Without RISCV_DIV_EARLY_OUT_EN, those cases SHALL take the full N+1 latency and still produce the REQ-020 and REQ-021 values.

Verification
REQ-028 DIVU rs1=100, rs2=7, start held -> stall high for cycles 0..64, valid at cycle 65, result 14; REMU same operands -> result 2.
REQ-029 DIV rs1=-20, rs2=3 -> result 0xFFFFFFFFFFFFFFFA (-6); REM -> 0xFFFFFFFFFFFFFFFE (-2); both with valid at cycle 65.
REQ-030 DIVW rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFF80000000, valid at cycle 33; REMUW rs1=0x12345678_FFFFFFF0, rs2=0x10 -> result 0.
REQ-031 DIVU rs1=5, rs2=0 -> result 0xFFFFFFFFFFFFFFFF; REM rs1=5, rs2=0 -> result 5. With the macro: valid at cycle 1. Without the macro: valid at cycle 65.
REQ-032 DIVU started, then flush at BUSY cycle 10 -> no valid pulse, stall 0 from cycle 11, and a new DIVU 9/3 started at cycle 11 -> result 3 at cycle 76.
REQ-033 Reset asserted at BUSY cycle 20 -> valid, result and stall 0 immediately, with no valid pulse after release.
